// File: rtl/mano_control_unit_if.sv
// Control-unit side of the basic computer: datapath status in, register/bus/ALU strobes out.
// The master modport belongs to the control unit, the slave modport to the datapath.
interface mano_control_unit_if #(
    parameter int WIDTH   = 16,
    parameter int SC_BITS = 4
);
    logic               run;
    logic [WIDTH-1:0]   ir;
    logic               ac_zero;
    logic               ac_msb;
    logic               dr_zero;
    logic               e_flag;

    logic [2:0]         bus_sel;
    logic               mem_read;
    logic               mem_write;
    logic               ld_ar;
    logic               inc_ar;
    logic               clr_ar;
    logic               ld_pc;
    logic               inc_pc;
    logic               ld_dr;
    logic               inc_dr;
    logic               ld_ac;
    logic               inc_ac;
    logic               clr_ac;
    logic               ld_ir;
    logic               ld_tr;
    logic [2:0]         alu_op;
    logic               clr_e;
    logic               cme;
    logic               ld_e;
    logic [SC_BITS-1:0] sc;
    logic               halted;

    modport master (
        input  run, ir, ac_zero, ac_msb, dr_zero, e_flag,
        output bus_sel, mem_read, mem_write,
        output ld_ar, inc_ar, clr_ar, ld_pc, inc_pc, ld_dr, inc_dr,
        output ld_ac, inc_ac, clr_ac, ld_ir, ld_tr, alu_op,
        output clr_e, cme, ld_e, sc, halted
    );

    modport slave (
        output run, ir, ac_zero, ac_msb, dr_zero, e_flag,
        input  bus_sel, mem_read, mem_write,
        input  ld_ar, inc_ar, clr_ar, ld_pc, inc_pc, ld_dr, inc_dr,
        input  ld_ac, inc_ac, clr_ac, ld_ir, ld_tr, alu_op,
        input  clr_e, cme, ld_e, sc, halted
    );
endinterface

// File: rtl/mano_control_unit.sv
// Timing and control sequencer for the basic computer: SC-driven fetch, decode,
// indirect, memory-reference and register-reference micro-operations.
module mano_control_unit #(
    parameter int WIDTH   = 16,
    parameter int SC_BITS = 4
) (
    input  logic                clk,
    input  logic                reset_cu,
    mano_control_unit_if.master cu
);

    typedef enum logic [2:0] {
        T0, T1, T2, T3, T4, T5, T6, T_WRAP
    } phase_t;

    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_AR   = 3'd1;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_DR   = 3'd3;
    localparam logic [2:0] BUS_AC   = 3'd4;
    localparam logic [2:0] BUS_IR   = 3'd5;
    localparam logic [2:0] BUS_MEM  = 3'd7;

    localparam logic [2:0] ALU_AND  = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_DR   = 3'd2;
    localparam logic [2:0] ALU_CMA  = 3'd3;
    localparam logic [2:0] ALU_CIR  = 3'd4;
    localparam logic [2:0] ALU_CIL  = 3'd5;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_ADD   = 3'd1;
    localparam logic [2:0] OP_LDA   = 3'd2;
    localparam logic [2:0] OP_STA   = 3'd3;
    localparam logic [2:0] OP_BUN   = 3'd4;
    localparam logic [2:0] OP_BSA   = 3'd5;
    localparam logic [2:0] OP_ISZ   = 3'd6;
    localparam logic [2:0] OP_REG   = 3'd7;

    logic [SC_BITS-1:0] sc_q, sc_d;
    logic               halted_q, halted_d;
    logic               i_q, i_d;
    logic [2:0]         op_q, op_d;
    logic               sc_clr;
    logic               active;
    phase_t             phase;

    assign active    = reset_cu & cu.run & ~halted_q;
    assign cu.sc     = sc_q;
    assign cu.halted = halted_q;
    assign cu.ld_tr  = 1'b0;
    assign cu.clr_ar = 1'b0;

    // Any count above T6 is illegal and maps to a recovery phase that just clears SC.
    always_comb begin
        if (sc_q > SC_BITS'(6)) begin
            phase = T_WRAP;
        end else begin
            phase = phase_t'(sc_q[2:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_cu) begin
            sc_q     <= '0;
            halted_q <= 1'b0;
            i_q      <= 1'b0;
            op_q     <= '0;
        end else begin
            sc_q     <= sc_d;
            halted_q <= halted_d;
            i_q      <= i_d;
            op_q     <= op_d;
        end
    end

    always_comb begin
        cu.bus_sel   = BUS_NONE;
        cu.mem_read  = 1'b0;
        cu.mem_write = 1'b0;
        cu.ld_ar     = 1'b0;
        cu.inc_ar    = 1'b0;
        cu.ld_pc     = 1'b0;
        cu.inc_pc    = 1'b0;
        cu.ld_dr     = 1'b0;
        cu.inc_dr    = 1'b0;
        cu.ld_ac     = 1'b0;
        cu.inc_ac    = 1'b0;
        cu.clr_ac    = 1'b0;
        cu.ld_ir     = 1'b0;
        cu.alu_op    = ALU_AND;
        cu.clr_e     = 1'b0;
        cu.cme       = 1'b0;
        cu.ld_e      = 1'b0;
        sc_d         = sc_q;
        halted_d     = halted_q;
        i_d          = i_q;
        op_d         = op_q;
        sc_clr       = 1'b0;

        if (active) begin
            case (phase)
                T0: begin
                    cu.bus_sel = BUS_PC;
                    cu.ld_ar   = 1'b1;
                end
                T1: begin
                    cu.bus_sel  = BUS_MEM;
                    cu.mem_read = 1'b1;
                    cu.ld_ir    = 1'b1;
                    cu.inc_pc   = 1'b1;
                end
                T2: begin
                    cu.bus_sel = BUS_IR;
                    cu.ld_ar   = 1'b1;
                    i_d        = cu.ir[WIDTH-1];
                    op_d       = cu.ir[WIDTH-2 -: 3];
                end
                T3: begin
                    if (op_q == OP_REG) begin
                        sc_clr = 1'b1;
                        // I=1 here is an I/O instruction, which this unit treats as a NOP.
                        if (!i_q) begin
                            cu.clr_e  = cu.ir[10];
                            cu.cme    = cu.ir[8];
                            cu.inc_pc = (cu.ir[4] & ~cu.ac_msb) | (cu.ir[3] & cu.ac_msb) |
                                        (cu.ir[2] & cu.ac_zero) | (cu.ir[1] & ~cu.e_flag);
                            if (cu.ir[11]) begin
                                cu.clr_ac = 1'b1;
                            end else if (cu.ir[9]) begin
                                cu.ld_ac  = 1'b1;
                                cu.alu_op = ALU_CMA;
                            end else if (cu.ir[7]) begin
                                cu.ld_ac  = 1'b1;
                                cu.alu_op = ALU_CIR;
                                cu.ld_e   = 1'b1;
                            end else if (cu.ir[6]) begin
                                cu.ld_ac  = 1'b1;
                                cu.alu_op = ALU_CIL;
                                cu.ld_e   = 1'b1;
                            end else if (cu.ir[5]) begin
                                cu.inc_ac = 1'b1;
                            end
                            if (cu.ir[0]) begin
                                halted_d = 1'b1;
                            end
                        end
                    end else if (i_q) begin
                        cu.bus_sel  = BUS_MEM;
                        cu.mem_read = 1'b1;
                        cu.ld_ar    = 1'b1;
                    end
                end
                T4: begin
                    case (op_q)
                        OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                            cu.bus_sel  = BUS_MEM;
                            cu.mem_read = 1'b1;
                            cu.ld_dr    = 1'b1;
                        end
                        OP_STA: begin
                            cu.bus_sel   = BUS_AC;
                            cu.mem_write = 1'b1;
                            sc_clr       = 1'b1;
                        end
                        OP_BUN: begin
                            cu.bus_sel = BUS_AR;
                            cu.ld_pc   = 1'b1;
                            sc_clr     = 1'b1;
                        end
                        OP_BSA: begin
                            cu.bus_sel   = BUS_PC;
                            cu.mem_write = 1'b1;
                            cu.inc_ar    = 1'b1;
                        end
                        default: sc_clr = 1'b1;
                    endcase
                end
                T5: begin
                    case (op_q)
                        OP_AND: begin
                            cu.ld_ac  = 1'b1;
                            cu.alu_op = ALU_AND;
                            sc_clr    = 1'b1;
                        end
                        OP_ADD: begin
                            cu.ld_ac  = 1'b1;
                            cu.alu_op = ALU_ADD;
                            cu.ld_e   = 1'b1;
                            sc_clr    = 1'b1;
                        end
                        OP_LDA: begin
                            cu.ld_ac  = 1'b1;
                            cu.alu_op = ALU_DR;
                            sc_clr    = 1'b1;
                        end
                        OP_BSA: begin
                            cu.bus_sel = BUS_AR;
                            cu.ld_pc   = 1'b1;
                            sc_clr     = 1'b1;
                        end
                        OP_ISZ: begin
                            cu.inc_dr = 1'b1;
                        end
                        default: sc_clr = 1'b1;
                    endcase
                end
                T6: begin
                    sc_clr = 1'b1;
                    // dr_zero already reflects the T5 increment when it is sampled here.
                    if (op_q == OP_ISZ) begin
                        cu.bus_sel   = BUS_DR;
                        cu.mem_write = 1'b1;
                        cu.inc_pc    = cu.dr_zero;
                    end
                end
                default: sc_clr = 1'b1;
            endcase

            sc_d = sc_clr ? '0 : sc_q + SC_BITS'(1);
        end
    end

endmodule

// File: tb/tb_mano_control_unit.sv
// Bench for mano_control_unit: directed test-plan sequences with literal expectations,
// then randomized instruction streams compared every cycle against a behavioural model.
module tb_mano_control_unit;

    typedef struct packed {
        logic [2:0] bus_sel;
        logic       mem_read;
        logic       mem_write;
        logic       ld_ar;
        logic       inc_ar;
        logic       clr_ar;
        logic       ld_pc;
        logic       inc_pc;
        logic       ld_dr;
        logic       inc_dr;
        logic       ld_ac;
        logic       inc_ac;
        logic       clr_ac;
        logic       ld_ir;
        logic       ld_tr;
        logic [2:0] alu_op;
        logic       clr_e;
        logic       cme;
        logic       ld_e;
    } ctl_t;

    typedef struct packed {
        logic [3:0] sc;
        logic       halted;
        logic       i;
        logic [2:0] op;
    } mstate_t;

    logic    clk = 1'b0;
    logic    reset_cu = 1'b0;
    int      checks = 0;
    int      errors = 0;
    logic    checkEn = 1'b0;
    mstate_t m = '0;
    ctl_t    dutC;
    ctl_t    expC;

    mano_control_unit_if bus ();

    mano_control_unit dut (
        .clk      (clk),
        .reset_cu (reset_cu),
        .cu       (bus)
    );

    always #5 clk = ~clk;

    assign dutC = {bus.bus_sel, bus.mem_read, bus.mem_write, bus.ld_ar, bus.inc_ar, bus.clr_ar,
                   bus.ld_pc, bus.inc_pc, bus.ld_dr, bus.inc_dr, bus.ld_ac, bus.inc_ac,
                   bus.clr_ac, bus.ld_ir, bus.ld_tr, bus.alu_op, bus.clr_e, bus.cme, bus.ld_e};

    // Cycles each instruction class lasts, counted as the last T-step index.
    function automatic int lastStep(logic [2:0] op);
        int table_q [0:7];
        table_q = '{5, 5, 5, 4, 4, 5, 6, 3};
        return table_q[op];
    endfunction

    function automatic mstate_t modelNext(mstate_t s, logic rstn, logic runv, logic [15:0] irv);
        mstate_t n;
        n = s;
        if (!rstn) begin
            n = '0;
        end else if (runv && !s.halted) begin
            if (s.sc == 4'd2) begin
                n.i  = irv[15];
                n.op = irv[14:12];
            end
            if (s.sc >= 4'd3 && int'(s.sc) >= lastStep(s.op)) n.sc = 4'd0;
            else n.sc = s.sc + 4'd1;
            if (s.sc == 4'd3 && s.op == 3'd7 && !s.i && irv[0]) n.halted = 1'b1;
        end
        return n;
    endfunction

    function automatic ctl_t regRef(logic [15:0] irv, logic az, logic am, logic ef);
        ctl_t c;
        int   acBits [5];
        int   pick;
        c = '0;
        acBits = '{11, 9, 7, 6, 5};
        pick = -1;
        for (int k = 0; k < 5; k++) begin
            if (pick < 0 && irv[acBits[k]]) pick = acBits[k];
        end
        case (pick)
            11: c.clr_ac = 1'b1;
            9:  begin c.ld_ac = 1'b1; c.alu_op = 3'd3; end
            7:  begin c.ld_ac = 1'b1; c.alu_op = 3'd4; c.ld_e = 1'b1; end
            6:  begin c.ld_ac = 1'b1; c.alu_op = 3'd5; c.ld_e = 1'b1; end
            5:  c.inc_ac = 1'b1;
            default: ;
        endcase
        c.clr_e  = irv[10];
        c.cme    = irv[8];
        c.inc_pc = (irv[4] && !am) || (irv[3] && am) || (irv[2] && az) || (irv[1] && !ef);
        return c;
    endfunction

    function automatic ctl_t memRef(logic [2:0] op, int k, logic dz);
        ctl_t c;
        c = '0;
        if (k == 0 && (op <= 3'd2 || op == 3'd6)) begin
            c.bus_sel = 3'd7; c.mem_read = 1'b1; c.ld_dr = 1'b1;
        end else if (k == 1 && op <= 3'd2) begin
            c.ld_ac = 1'b1; c.alu_op = op; c.ld_e = (op == 3'd1);
        end else if (op == 3'd3 && k == 0) begin
            c.bus_sel = 3'd4; c.mem_write = 1'b1;
        end else if (op == 3'd4 && k == 0) begin
            c.bus_sel = 3'd1; c.ld_pc = 1'b1;
        end else if (op == 3'd5 && k == 0) begin
            c.bus_sel = 3'd2; c.mem_write = 1'b1; c.inc_ar = 1'b1;
        end else if (op == 3'd5 && k == 1) begin
            c.bus_sel = 3'd1; c.ld_pc = 1'b1;
        end else if (op == 3'd6 && k == 1) begin
            c.inc_dr = 1'b1;
        end else if (op == 3'd6 && k == 2) begin
            c.bus_sel = 3'd3; c.mem_write = 1'b1; c.inc_pc = dz;
        end
        return c;
    endfunction

    function automatic ctl_t modelOut(mstate_t s, logic rstn, logic runv, logic [15:0] irv,
                                      logic az, logic am, logic dz, logic ef);
        ctl_t c;
        c = '0;
        if (!rstn || !runv || s.halted) return c;
        case (s.sc)
            4'd0: begin c.bus_sel = 3'd2; c.ld_ar = 1'b1; end
            4'd1: begin c.bus_sel = 3'd7; c.mem_read = 1'b1; c.ld_ir = 1'b1; c.inc_pc = 1'b1; end
            4'd2: begin c.bus_sel = 3'd5; c.ld_ar = 1'b1; end
            4'd3: begin
                if (s.op == 3'd7) begin
                    if (!s.i) c = regRef(irv, az, am, ef);
                end else if (s.i) begin
                    c.bus_sel = 3'd7; c.mem_read = 1'b1; c.ld_ar = 1'b1;
                end
            end
            default: c = memRef(s.op, int'(s.sc) - 4, dz);
        endcase
        return c;
    endfunction

    always @(posedge clk) begin
        m <= modelNext(m, reset_cu, bus.run, bus.ir);
    end

    always @(negedge clk) begin
        if (checkEn) begin
            expC = modelOut(m, reset_cu, bus.run, bus.ir, bus.ac_zero, bus.ac_msb,
                            bus.dr_zero, bus.e_flag);
            checks++;
            if (dutC !== expC) begin
                errors++;
                $display("[TB] FAIL model_ctl t=%0t sc=%0d actual=%h required=%h", $time, m.sc, dutC, expC);
            end
            checks++;
            if (bus.sc !== m.sc) begin
                errors++;
                $display("[TB] FAIL model_sc t=%0t actual=%0d required=%0d", $time, bus.sc, m.sc);
            end
            checks++;
            if (bus.halted !== m.halted) begin
                errors++;
                $display("[TB] FAIL model_halted t=%0t actual=%0d required=%0d", $time, bus.halted, m.halted);
            end
        end
    end

    task automatic applyStimulus(input logic rstn, input logic runv, input logic [15:0] irv,
                                 input logic az, input logic am, input logic dz, input logic ef);
        @(posedge clk);
        #1;
        reset_cu    = rstn;
        bus.run     = runv;
        bus.ir      = irv;
        bus.ac_zero = az;
        bus.ac_msb  = am;
        bus.dr_zero = dz;
        bus.e_flag  = ef;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    initial begin
        bus.run = 1'b0;
        bus.ir = '0;
        bus.ac_zero = 1'b0;
        bus.ac_msb = 1'b0;
        bus.dr_zero = 1'b0;
        bus.e_flag = 1'b0;

        applyStimulus(1'b0, 1'b1, 16'h0000, 0, 0, 0, 0);
        checkOutput("reset_sc", 32'(bus.sc), 0);
        checkOutput("reset_bus_sel", 32'(bus.bus_sel), 0);
        checkOutput("reset_ld_ar", 32'(bus.ld_ar), 0);
        checkEn = 1'b1;
        $display("[TB] directed sequences");

        for (int t = 0; t < 6; t++) begin
            applyStimulus(1'b1, 1'b1, 16'h2005, 0, 0, 0, 0);
            checkOutput("lda_sc", 32'(bus.sc), 32'(t));
            if (t == 0) begin
                checkOutput("lda_t0_bus", 32'(bus.bus_sel), 2);
                checkOutput("lda_t0_ld_ar", 32'(bus.ld_ar), 1);
            end
            if (t == 1) begin
                checkOutput("lda_t1_mem_read", 32'(bus.mem_read), 1);
                checkOutput("lda_t1_ld_ir", 32'(bus.ld_ir), 1);
                checkOutput("lda_t1_inc_pc", 32'(bus.inc_pc), 1);
            end
            if (t == 5) begin
                checkOutput("lda_t5_ld_ac", 32'(bus.ld_ac), 1);
                checkOutput("lda_t5_alu", 32'(bus.alu_op), 2);
            end
        end

        for (int t = 0; t < 5; t++) begin
            applyStimulus(1'b1, 1'b1, 16'hC010, 0, 0, 0, 0);
            checkOutput("bun_sc", 32'(bus.sc), 32'(t));
            if (t == 3) begin
                checkOutput("bun_t3_bus", 32'(bus.bus_sel), 7);
                checkOutput("bun_t3_ld_ar", 32'(bus.ld_ar), 1);
                checkOutput("bun_t3_mem_read", 32'(bus.mem_read), 1);
            end
            if (t == 4) begin
                checkOutput("bun_t4_bus", 32'(bus.bus_sel), 1);
                checkOutput("bun_t4_ld_pc", 32'(bus.ld_pc), 1);
            end
        end

        for (int pass = 0; pass < 2; pass++) begin
            for (int t = 0; t < 7; t++) begin
                applyStimulus(1'b1, 1'b1, 16'h6020, 0, 0, (t == 6) && (pass == 0), 0);
                checkOutput("isz_sc", 32'(bus.sc), 32'(t));
                if (t == 6) begin
                    checkOutput("isz_t6_mem_write", 32'(bus.mem_write), 1);
                    checkOutput("isz_t6_inc_pc", 32'(bus.inc_pc), (pass == 0) ? 1 : 0);
                end
            end
        end

        for (int t = 0; t < 4; t++) begin
            applyStimulus(1'b1, 1'b1, 16'h7820, 0, 0, 0, 0);
            if (t == 3) begin
                checkOutput("cla_inc_clr_ac", 32'(bus.clr_ac), 1);
                checkOutput("cla_inc_inc_ac", 32'(bus.inc_ac), 0);
            end
        end

        for (int t = 0; t < 4; t++) begin
            applyStimulus(1'b1, 1'b1, 16'h7004, 1, 0, 0, 0);
            if (t == 3) checkOutput("sza_inc_pc", 32'(bus.inc_pc), 1);
        end

        for (int t = 0; t < 4; t++) applyStimulus(1'b1, 1'b1, 16'h1000, 0, 0, 0, 0);
        for (int t = 0; t < 3; t++) begin
            applyStimulus(1'b1, 1'b0, 16'h1000, 0, 0, 0, 0);
            checkOutput("add_paused_sc", 32'(bus.sc), 4);
            checkOutput("add_paused_ctl", 32'(dutC), 0);
        end
        applyStimulus(1'b1, 1'b1, 16'h1000, 0, 0, 0, 0);
        checkOutput("add_resume_sc", 32'(bus.sc), 4);
        checkOutput("add_resume_ld_dr", 32'(bus.ld_dr), 1);
        applyStimulus(1'b1, 1'b1, 16'h1000, 0, 0, 0, 0);
        checkOutput("add_t5_ld_ac", 32'(bus.ld_ac), 1);
        checkOutput("add_t5_alu", 32'(bus.alu_op), 1);
        checkOutput("add_t5_ld_e", 32'(bus.ld_e), 1);

        for (int t = 0; t < 5; t++) applyStimulus(1'b1, 1'b1, 16'h5000, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b1, 16'h5000, 0, 0, 0, 0);
        checkOutput("bsa_reset_ld_pc", 32'(bus.ld_pc), 0);
        applyStimulus(1'b1, 1'b1, 16'h2005, 0, 0, 0, 0);
        checkOutput("bsa_after_reset_sc", 32'(bus.sc), 0);
        checkOutput("bsa_after_reset_bus", 32'(bus.bus_sel), 2);
        checkOutput("bsa_after_reset_ld_ar", 32'(bus.ld_ar), 1);
        for (int t = 1; t < 6; t++) applyStimulus(1'b1, 1'b1, 16'h2005, 0, 0, 0, 0);

        for (int t = 0; t < 4; t++) applyStimulus(1'b1, 1'b1, 16'h7001, 0, 0, 0, 0);
        for (int t = 0; t < 10; t++) begin
            applyStimulus(1'b1, 1'b1, 16'h7001, 0, 0, 0, 0);
            checkOutput("hlt_halted", 32'(bus.halted), 1);
            checkOutput("hlt_sc", 32'(bus.sc), 0);
            checkOutput("hlt_ld_ar", 32'(bus.ld_ar), 0);
        end

        applyStimulus(1'b0, 1'b1, 16'h0000, 0, 0, 0, 0);
        $display("[TB] randomized instruction stream");
        for (int n = 0; n < 4000; n++) begin
            logic [15:0] irv;
            logic        rstn;
            logic        runv;
            irv  = 16'($urandom);
            if ($urandom_range(0, 15) != 0) irv[0] = 1'b0;
            rstn = ($urandom_range(0, 199) != 0);
            runv = ($urandom_range(0, 7) != 0);
            applyStimulus(rstn, runv, irv, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
